// File: rtl/vx_dcache_arb_pkg.sv
// Shared helpers for the dcache request arbiter: index and tag widths.
package vx_dcache_arb_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_out_width(input int num_inputs, input int tag_in_width);
        return tag_in_width + clog2_min1(num_inputs);
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the priority pointer wins.
module vx_rr_arbiter
    import vx_dcache_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  requests,
    input  logic          advance,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    logic [IW-1:0] ptr;

    // Two passes replace a modulo rotate, so non-power-of-2 N needs no wrap math.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        valid        = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!valid && requests[j] && (j >= int'(ptr))) begin
                valid           = 1'b1;
                grant_idx       = IW'(j);
                grant_onehot[j] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!valid && requests[j] && (j < int'(ptr))) begin
                valid           = 1'b1;
                grant_idx       = IW'(j);
                grant_onehot[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && valid) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vx_dcache_req_arb.sv
// Merges requester bundles onto one registered dcache request bundle,
// tagging each lane with the index of the requester that produced it.
module vx_dcache_req_arb
    import vx_dcache_arb_pkg::*;
#(
    parameter int NUM_INPUTS   = 2,
    parameter int NUM_REQS     = 4,
    parameter int WORD_SIZE    = 4,
    parameter int ADDR_WIDTH   = 30,
    parameter int TAG_IN_WIDTH = 8,
    localparam int DW  = 8 * WORD_SIZE,
    localparam int IW  = clog2_min1(NUM_INPUTS),
    localparam int TOW = tag_out_width(NUM_INPUTS, TAG_IN_WIDTH)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]             req_valid_in,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]             req_rw_in,
    input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE-1:0]   req_byteen_in,
    input  logic [NUM_INPUTS*NUM_REQS*ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_INPUTS*NUM_REQS*DW-1:0]          req_data_in,
    input  logic [NUM_INPUTS*NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_INPUTS-1:0]                      req_ready_in,
    output logic [NUM_REQS-1:0]                        req_valid_out,
    output logic [NUM_REQS-1:0]                        req_rw_out,
    output logic [NUM_REQS*WORD_SIZE-1:0]              req_byteen_out,
    output logic [NUM_REQS*ADDR_WIDTH-1:0]             req_addr_out,
    output logic [NUM_REQS*DW-1:0]                     req_data_out,
    output logic [NUM_REQS*TOW-1:0]                    req_tag_out,
    input  logic [NUM_REQS-1:0]                        req_ready_out
);

    logic [NUM_INPUTS-1:0] requests;
    logic [NUM_INPUTS-1:0] grant_onehot;
    logic [IW-1:0]         grant_idx;
    logic                  grant_valid;
    logic                  can_load;
    logic                  load;
    logic [NUM_REQS-1:0]   v;

    logic [NUM_REQS-1:0]              sel_valid;
    logic [NUM_REQS-1:0]              sel_rw;
    logic [NUM_REQS*WORD_SIZE-1:0]    sel_byteen;
    logic [NUM_REQS*ADDR_WIDTH-1:0]   sel_addr;
    logic [NUM_REQS*DW-1:0]           sel_data;
    logic [NUM_REQS*TAG_IN_WIDTH-1:0] sel_tag;
    logic [NUM_REQS*TOW-1:0]          tag_next;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
        assign requests[i] = |req_valid_in[i*NUM_REQS +: NUM_REQS];
    end

    vx_rr_arbiter #(
        .N (NUM_INPUTS)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (requests),
        .advance      (load),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .valid        (grant_valid)
    );

    // Stage can take a new bundle once every occupied lane drains this cycle.
    assign can_load     = &(~v | req_ready_out);
    assign load         = can_load && grant_valid && !reset;
    assign req_ready_in = (can_load && !reset) ? grant_onehot : '0;

    always_comb begin
        sel_valid  = '0;
        sel_rw     = '0;
        sel_byteen = '0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_tag    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_onehot[i]) begin
                sel_valid  = req_valid_in[i*NUM_REQS +: NUM_REQS];
                sel_rw     = req_rw_in[i*NUM_REQS +: NUM_REQS];
                sel_byteen = req_byteen_in[i*NUM_REQS*WORD_SIZE +: NUM_REQS*WORD_SIZE];
                sel_addr   = req_addr_in[i*NUM_REQS*ADDR_WIDTH +: NUM_REQS*ADDR_WIDTH];
                sel_data   = req_data_in[i*NUM_REQS*DW +: NUM_REQS*DW];
                sel_tag    = req_tag_in[i*NUM_REQS*TAG_IN_WIDTH +: NUM_REQS*TAG_IN_WIDTH];
            end
        end
    end

    always_comb begin
        tag_next = '0;
        for (int l = 0; l < NUM_REQS; l++) begin
            tag_next[l*TOW +: TOW] = {sel_tag[l*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else if (load) begin
            v <= sel_valid;
        end else begin
            v <= v & ~req_ready_out;
        end
    end

    // Payload is don't-care while its lane valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            req_rw_out     <= sel_rw;
            req_byteen_out <= sel_byteen;
            req_addr_out   <= sel_addr;
            req_data_out   <= sel_data;
            req_tag_out    <= tag_next;
        end
    end

    assign req_valid_out = v;

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Scoreboard bench for vx_dcache_req_arb: directed vectors plus a random phase.
module tb_vx_dcache_req_arb;

    localparam int NI  = 2;
    localparam int NR  = 4;
    localparam int WS  = 4;
    localparam int AW  = 30;
    localparam int TW  = 8;
    localparam int DW  = 32;
    localparam int TOW = 9;
    localparam int EW  = 1 + WS + AW + DW + TOW;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [NI*NR-1:0]    req_valid_in = '0;
    logic [NI*NR-1:0]    req_rw_in = '0;
    logic [NI*NR*WS-1:0] req_byteen_in = '0;
    logic [NI*NR*AW-1:0] req_addr_in = '0;
    logic [NI*NR*DW-1:0] req_data_in = '0;
    logic [NI*NR*TW-1:0] req_tag_in = '0;
    logic [NI-1:0]       req_ready_in;
    logic [NR-1:0]       req_valid_out;
    logic [NR-1:0]       req_rw_out;
    logic [NR*WS-1:0]    req_byteen_out;
    logic [NR*AW-1:0]    req_addr_out;
    logic [NR*DW-1:0]    req_data_out;
    logic [NR*TOW-1:0]   req_tag_out;
    logic [NR-1:0]       req_ready_out = '0;

    logic [3*NR-1:0]    v3_valid = '0;
    logic [3*NR-1:0]    v3_rw = '0;
    logic [3*NR*WS-1:0] v3_be = '0;
    logic [3*NR*AW-1:0] v3_addr = '0;
    logic [3*NR*DW-1:0] v3_data = '0;
    logic [3*NR*TW-1:0] v3_tag = '0;
    logic [2:0]         v3_ready_in;
    logic [NR-1:0]      v3_valid_out;
    logic [NR-1:0]      v3_rw_out;
    logic [NR*WS-1:0]   v3_be_out;
    logic [NR*AW-1:0]   v3_addr_out;
    logic [NR*DW-1:0]   v3_data_out;
    logic [NR*10-1:0]   v3_tag_out;
    logic [NR-1:0]      v3_ready_out = 4'hF;

    vx_dcache_req_arb #(
        .NUM_INPUTS(NI), .NUM_REQS(NR), .WORD_SIZE(WS),
        .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in),
        .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in), .req_valid_out(req_valid_out),
        .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
        .req_addr_out(req_addr_out), .req_data_out(req_data_out),
        .req_tag_out(req_tag_out), .req_ready_out(req_ready_out)
    );

    vx_dcache_req_arb #(
        .NUM_INPUTS(3), .NUM_REQS(NR), .WORD_SIZE(WS),
        .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
    ) dut3 (
        .clk(clk), .reset(reset),
        .req_valid_in(v3_valid), .req_rw_in(v3_rw),
        .req_byteen_in(v3_be), .req_addr_in(v3_addr),
        .req_data_in(v3_data), .req_tag_in(v3_tag),
        .req_ready_in(v3_ready_in), .req_valid_out(v3_valid_out),
        .req_rw_out(v3_rw_out), .req_byteen_out(v3_be_out),
        .req_addr_out(v3_addr_out), .req_data_out(v3_data_out),
        .req_tag_out(v3_tag_out), .req_ready_out(v3_ready_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    logic [EW-1:0] q [NR][$];
    logic [NR-1:0] cur_valid [NI];
    logic [7:0]    cur_tag [NI];

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic f_rw(input int i, input int l, input logic [7:0] t);
        return t[l] ^ 1'(i);
    endfunction

    function automatic logic [WS-1:0] f_be(input int l, input logic [7:0] t);
        return t[3:0] ^ 4'(l);
    endfunction

    function automatic logic [AW-1:0] f_addr(input int i, input int l, input logic [7:0] t);
        return {6'(i), 8'(l), t, 8'hC3};
    endfunction

    function automatic logic [DW-1:0] f_data(input int i, input int l, input logic [7:0] t);
        return {t, 8'(i), 8'(l), ~t};
    endfunction

    function automatic logic [EW-1:0] exp_word(input int i, input int l, input logic [7:0] t);
        logic [7:0] lt;
        lt = t ^ 8'(l);
        return {f_rw(i, l, t), f_be(l, t), f_addr(i, l, t), f_data(i, l, t), lt, 1'(i)};
    endfunction

    task automatic drive_in(input int i, input logic [NR-1:0] valid, input logic [7:0] t);
        int idx;
        cur_valid[i] = valid;
        cur_tag[i] = t;
        for (int l = 0; l < NR; l++) begin
            idx = i * NR + l;
            req_valid_in[idx] = valid[l];
            req_rw_in[idx] = f_rw(i, l, t);
            req_byteen_in[idx*WS +: WS] = f_be(l, t);
            req_addr_in[idx*AW +: AW] = f_addr(i, l, t);
            req_data_in[idx*DW +: DW] = f_data(i, l, t);
            req_tag_in[idx*TW +: TW] = t ^ 8'(l);
        end
    endtask

    task automatic push_bundle(input int i);
        for (int l = 0; l < NR; l++)
            if (cur_valid[i][l]) q[l].push_back(exp_word(i, l, cur_tag[i]));
    endtask

    task automatic tick(input logic [NI-1:0] exp);
        @(negedge clk);
        check("ready_in", {126'd0, req_ready_in}, {126'd0, exp});
        for (int i = 0; i < NI; i++)
            if (exp[i]) push_bundle(i);
        @(posedge clk);
        #1;
    endtask

    task automatic flush_q();
        for (int l = 0; l < NR; l++) q[l].delete();
    endtask

    // Monitor: each lane handshake pops that lane's oldest expected word.
    always @(negedge clk) begin
        logic [EW-1:0] got;
        for (int l = 0; l < NR; l++) begin
            if (req_valid_out[l] && req_ready_out[l]) begin
                got = {req_rw_out[l], req_byteen_out[l*WS +: WS],
                       req_addr_out[l*AW +: AW], req_data_out[l*DW +: DW],
                       req_tag_out[l*TOW +: TOW]};
                if (q[l].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL lane%0d_dup: got %h expected nothing", l, got);
                end else begin
                    check($sformatf("lane%0d_word", l), {52'd0, got}, {52'd0, q[l].pop_front()});
                end
            end
        end
    end

    initial begin
        logic [NR-1:0] mv;
        logic [NI-1:0] acc;
        logic [NI-1:0] exp;
        logic [NR-1:0] nv;
        int mptr;
        int g;
        int j;

        for (int i = 0; i < NI; i++) begin
            cur_valid[i] = '0;
            cur_tag[i] = '0;
        end

        // Reset: outputs idle and no acceptance even with a request present.
        drive_in(0, 4'hF, 8'h11);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", {124'd0, req_valid_out}, 128'd0);
        check("rst_ready_in", {126'd0, req_ready_in}, 128'd0);
        drive_in(0, 4'h0, 8'h00);
        reset = 1'b0;
        req_ready_out = 4'hF;

        // Single input, sparse lanes, index appended in tag LSB.
        drive_in(1, 4'b0101, 8'hA5);
        tick(2'b10);
        drive_in(1, 4'h0, 8'h00);
        check("sparse_valid_out", {124'd0, req_valid_out}, {124'd0, 4'b0101});
        check("sparse_tag_l0", {119'd0, req_tag_out[8:0]}, {119'd0, 9'h14B});
        tick(2'b00);

        // Both requesting every cycle: strict alternation.
        drive_in(0, 4'hF, 8'h10);
        drive_in(1, 4'hF, 8'h20);
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            tick(g ? 2'b10 : 2'b01);
            check("alt_valid_out", {124'd0, req_valid_out}, {124'd0, 4'hF});
            check("alt_tag_lsb", {127'd0, req_tag_out[0]}, {127'd0, 1'(g)});
            drive_in(g, 4'hF, cur_tag[g] + 8'h1);
        end
        drive_in(0, 4'h0, 8'h00);
        drive_in(1, 4'h0, 8'h00);
        tick(2'b00);

        // Partial drain blocks loading until all lanes leave.
        req_ready_out = 4'h0;
        drive_in(0, 4'hF, 8'h30);
        tick(2'b01);
        drive_in(0, 4'hF, 8'h31);
        drive_in(1, 4'hF, 8'h40);
        req_ready_out = 4'b0011;
        check("pd_full", {124'd0, req_valid_out}, {124'd0, 4'hF});
        tick(2'b00);
        check("pd_half", {124'd0, req_valid_out}, {124'd0, 4'b1100});
        req_ready_out = 4'b1100;
        tick(2'b10);
        drive_in(1, 4'h0, 8'h00);
        req_ready_out = 4'hF;
        check("pd_reload", {124'd0, req_valid_out}, {124'd0, 4'hF});
        tick(2'b01);
        drive_in(0, 4'h0, 8'h00);
        tick(2'b00);

        // Reset mid-drain discards lanes and returns priority to input 0.
        req_ready_out = 4'h0;
        drive_in(0, 4'hF, 8'h50);
        tick(2'b01);
        drive_in(0, 4'hF, 8'h51);
        drive_in(1, 4'hF, 8'h60);
        check("mid_full", {124'd0, req_valid_out}, {124'd0, 4'hF});
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {124'd0, req_valid_out}, 128'd0);
        flush_q();
        @(negedge clk);
        check("mid_rst_ready", {126'd0, req_ready_in}, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_ready_out = 4'hF;
        tick(2'b01);
        drive_in(0, 4'h0, 8'h00);
        tick(2'b10);
        drive_in(1, 4'h0, 8'h00);
        tick(2'b00);

        // Three inputs: only input 2 requests, pointer wraps to 0.
        v3_valid[8 +: 4] = 4'hF;
        v3_tag[64 +: 32] = {4{8'h77}};
        @(negedge clk);
        check("n3_grant2", {125'd0, v3_ready_in}, {125'd0, 3'b100});
        @(posedge clk);
        #1;
        check("n3_valid_out", {124'd0, v3_valid_out}, {124'd0, 4'hF});
        check("n3_tag_l0", {118'd0, v3_tag_out[9:0]}, {118'd0, 10'h1DE});
        v3_valid[0 +: 4] = 4'hF;
        @(negedge clk);
        check("n3_wrap", {125'd0, v3_ready_in}, {125'd0, 3'b001});
        @(posedge clk);
        #1;
        v3_valid = '0;

        // Random stress against a small reference model of grant and stage state.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush_q();
        mv = '0;
        mptr = 0;
        acc = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (acc[i] || cur_valid[i] == '0) begin
                    nv = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                    drive_in(i, nv, 8'($urandom));
                end
            end
            for (int l = 0; l < NR; l++)
                req_ready_out[l] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            for (int k = 0; k < NI; k++) begin
                j = (mptr + k) % NI;
                if (g < 0 && cur_valid[j] != '0) g = j;
            end
            exp = '0;
            if ((&(~mv | req_ready_out)) && g >= 0) exp[g] = 1'b1;
            check("rr_ready_in", {126'd0, req_ready_in}, {126'd0, exp});
            acc = exp;
            if (exp != '0) begin
                push_bundle(g);
                mv = cur_valid[g];
                mptr = (g + 1) % NI;
            end else begin
                mv = mv & ~req_ready_out;
            end
            @(posedge clk);
            #1;
        end

        drive_in(0, 4'h0, 8'h00);
        drive_in(1, 4'h0, 8'h00);
        req_ready_out = 4'hF;
        repeat (3) tick(2'b00);
        for (int l = 0; l < NR; l++)
            check($sformatf("lane%0d_left", l), 128'(q[l].size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
